// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder/loader: opcode constants,
// instruction formats, the op->format map and the loader FSM states.
package isa_pkg;

  localparam logic [4:0] OP_LD     = 5'd12;
  localparam logic [4:0] OP_ST     = 5'd13;
  // R-type opcodes are 0..6 plus 11
  localparam logic [4:0] OP_R_LAST = 5'd6;
  localparam logic [4:0] OP_R_EXT  = 5'd11;

  typedef logic [19:0] inst_t;

  typedef enum logic [1:0] {FMT_R, FMT_LD, FMT_ST, FMT_J} fmt_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  function automatic fmt_e fmt_of(input logic [4:0] op);
    fmt_e f;
    if (op <= OP_R_LAST || op == OP_R_EXT) f = FMT_R;
    else if (op == OP_LD)                  f = FMT_LD;
    else if (op == OP_ST)                  f = FMT_ST;
    else                                   f = FMT_J;
    return f;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Small synchronous FIFO holding encoded instruction words between the
// input handshake and the imem write port. DEPTH must be a power of two >= 2.
module enc_fifo
  import isa_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  inst_t wdata,
  output inst_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int PW = $clog2(DEPTH);

  inst_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/inst_enc_loader.sv
// Packs instruction fields into 20-bit words and streams them into imem from a
// base address. Optional field checking is enabled by defining INST_ENC_CHECK_EN.
//
// state   | meaning
// S_IDLE  | waiting for start; base address captured on start
// S_RUN   | accepting bundles and draining the FIFO
// S_DRAIN | last bundle taken; emptying FIFO and finishing the final write
// S_DONE  | one-cycle done pulse, then back to idle
module inst_enc_loader
  import isa_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [14:0]   in_bamt,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [19:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          enc_err
);

  state_e        state, state_nxt;
  logic [AW-1:0] addr_cnt;
  fmt_e          fmt;
  logic [14:0]   payload;
  inst_t         enc_word;
  inst_t         fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic          push, pop;

  assign fmt      = fmt_of(in_op);
  assign in_ready = (state == S_RUN) && !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_RUN || state == S_DRAIN) && !fifo_empty;
  assign busy     = (state == S_RUN || state == S_DRAIN);
  assign done     = (state == S_DONE);

  always_comb begin
    payload = in_bamt;
    case (fmt)
      FMT_R:   payload = {in_rd, in_rs, in_rt};
      FMT_LD:  payload = {in_rd, in_rt, in_rs};
      FMT_ST:  payload = {in_rs, in_rd, 5'b0};
      default: payload = in_bamt;
    endcase
  end

  assign enc_word = {in_op, payload};

  enc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (enc_word),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (push && in_last) state_nxt = S_DRAIN;
      // wait until the final registered write has been presented
      S_DRAIN: if (fifo_empty && !imem_we) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state   <= state_nxt;
      imem_we <= pop;
      if (state == S_IDLE && start) addr_cnt <= base_addr;
      else if (pop)                 addr_cnt <= addr_cnt + 1'b1;
      if (pop) begin
        imem_addr  <= addr_cnt;
        imem_wdata <= fifo_rdata;
      end
    end
  end

`ifdef INST_ENC_CHECK_EN
  logic field_bad;

  always_comb begin
    field_bad = 1'b0;
    case (fmt)
      FMT_ST:  field_bad = (in_rt != 5'd0) || (in_bamt != 15'd0);
      FMT_J:   field_bad = ((in_rd | in_rs | in_rt) != 5'd0);
      default: field_bad = (in_bamt != 15'd0);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      enc_err <= 1'b0;
    else if (state == S_IDLE && start) enc_err <= 1'b0;
    else if (push && field_bad)      enc_err <= 1'b1;
  end
`else
  assign enc_err = 1'b0;
`endif

endmodule
